// File: rtl/rom_stream_pkg.sv
// Shared types and default widths for the ROM stream reader.
// Optional checksum output is enabled with ROM_STREAM_CHECKSUM_EN.
package rom_stream_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rom_stream_reader.sv
// Walks an address window of a combinational ROM and streams each word out on valid/ready.
// Define ROM_STREAM_CHECKSUM_EN to add a running XOR checksum output (csum).
//
// state | meaning
// IDLE  | waiting for start; base/len sampled here only
// FETCH | rom_addr stable for a full cycle, ROM data captured at the edge
// SEND  | m_valid high, m_data held until the handshake
// DONE  | one-cycle done pulse, then back to IDLE
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int ADDR_W = rom_stream_pkg::ADDR_W,
    parameter int DATA_W = rom_stream_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
`ifdef ROM_STREAM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [ADDR_W:0]     r_cnt;
    logic [ADDR_W:0]     w_cnt_nxt;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic                w_hs;
    logic [DATA_W-1:0]   r_csum;
    logic [DATA_W-1:0]   w_csum_nxt;

    assign w_hs = r_valid & m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_csum  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_csum  <= w_csum_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_csum_nxt  = r_csum;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_csum_nxt = '0;
                    if (len != '0) begin
                        w_addr_nxt  = base;
                        w_cnt_nxt   = len;
                        w_state_nxt = FETCH;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            FETCH: begin
                w_data_nxt  = rom_dout;
                w_valid_nxt = 1'b1;
                w_state_nxt = SEND;
            end
            SEND: begin
                if (w_hs) begin
                    w_valid_nxt = 1'b0;
                    w_csum_nxt  = r_csum ^ r_data;
                    if (r_cnt == CNT_ONE) begin
                        w_state_nxt = DONE;
                    end else begin
                        // Address wraps naturally modulo 2**ADDR_W.
                        w_cnt_nxt   = r_cnt - CNT_ONE;
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_state_nxt = FETCH;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign rom_addr = r_addr;
    assign m_data   = r_data;
    assign m_valid  = r_valid;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);

`ifdef ROM_STREAM_CHECKSUM_EN
    assign csum = r_csum;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed self-checking bench for rom_stream_reader with a 4-word combinational ROM responder.
// Checksum results are also checked when ROM_STREAM_CHECKSUM_EN is defined.
module tb_rom_stream_reader;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 14;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              busy;
    logic              done;
`ifdef ROM_STREAM_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    int n_vec;
    int n_err;

    rom_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base),
        .len      (len),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy),
        .done     (done)
`ifdef ROM_STREAM_CHECKSUM_EN
        ,
        .csum     (csum)
`endif
    );

    always_comb begin
        case (rom_addr)
            2'd0:    rom_dout = 14'h0001;
            2'd1:    rom_dout = 14'h0F0F;
            2'd2:    rom_dout = 14'h3FFF;
            default: rom_dout = 14'h2AAA;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for m_valid, checks the beat, then lets one edge pass to consume it.
    task automatic expect_beat(input string tag, input logic [DATA_W-1:0] exp);
        int k;
        k = 0;
        while (m_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_data"}, 32'(m_data), 32'(exp));
        tick();
    endtask

    initial begin
        int seen_valid;
        int seen_done;
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        base    = '0;
        len     = '0;
        m_ready = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Full read: base=0, len=4, m_ready high
        start = 1'b1; base = 2'd0; len = 3'd4; m_ready = 1'b1;
        tick();
        start = 1'b0;
        check("full_lat1_valid", 32'(m_valid), 32'd0);
        check("full_lat1_busy", 32'(busy), 32'd1);
        tick();
        check("full_lat2_valid", 32'(m_valid), 32'd1);
        expect_beat("full_b0", 14'h0001);
        expect_beat("full_b1", 14'h0F0F);
        expect_beat("full_b2", 14'h3FFF);
        expect_beat("full_b3", 14'h2AAA);
        check("full_done", 32'(done), 32'd1);
        check("full_done_busy", 32'(busy), 32'd1);
        check("full_done_valid", 32'(m_valid), 32'd0);
`ifdef ROM_STREAM_CHECKSUM_EN
        check("full_csum", 32'(csum), 32'h1A5B);
`endif
        tick();
        check("full_done_once", 32'(done), 32'd0);
        check("full_idle_busy", 32'(busy), 32'd0);
`ifdef ROM_STREAM_CHECKSUM_EN
        check("full_csum_hold", 32'(csum), 32'h1A5B);
`endif

        // Wrap: base=3, len=2 reads 3 then 0
        start = 1'b1; base = 2'd3; len = 3'd2;
        tick();
        start = 1'b0;
        check("wrap_addr0", 32'(rom_addr), 32'd3);
        tick();
        check("wrap_b0", 32'(m_data), 32'h2AAA);
        tick();
        check("wrap_addr1", 32'(rom_addr), 32'd0);
        tick();
        check("wrap_b1_valid", 32'(m_valid), 32'd1);
        check("wrap_b1", 32'(m_data), 32'h0001);
        tick();
        check("wrap_done", 32'(done), 32'd1);
`ifdef ROM_STREAM_CHECKSUM_EN
        check("wrap_csum", 32'(csum), 32'h2AAB);
`endif
        tick();
        check("wrap_busy_fall", 32'(busy), 32'd0);

        // Backpressure: base=1, len=2, first beat stalled 5 cycles
        m_ready = 1'b0;
        start = 1'b1; base = 2'd1; len = 3'd2;
        tick();
        start = 1'b0;
        tick();
        check("bp_first", 32'(m_data), 32'h0F0F);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold_valid%0d", i), 32'(m_valid), 32'd1);
            check($sformatf("bp_hold_data%0d", i), 32'(m_data), 32'h0F0F);
        end
        m_ready = 1'b1;
        tick();
        check("bp_after_hs_valid", 32'(m_valid), 32'd0);
        tick();
        check("bp_b1", 32'(m_data), 32'h3FFF);
        tick();
        check("bp_done", 32'(done), 32'd1);
        tick();

        // Zero length burst
        start = 1'b1; base = 2'd2; len = 3'd0;
        tick();
        start = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd1);
        check("zero_valid", 32'(m_valid), 32'd0);
`ifdef ROM_STREAM_CHECKSUM_EN
        check("zero_csum", 32'(csum), 32'd0);
`endif
        tick();
        check("zero_done_end", 32'(done), 32'd0);
        check("zero_busy_end", 32'(busy), 32'd0);
        check("zero_valid_end", 32'(m_valid), 32'd0);

        // Start while busy is ignored
        start = 1'b1; base = 2'd0; len = 3'd4;
        tick();
        start = 1'b0;
        tick();
        check("sb_b0", 32'(m_data), 32'h0001);
        start = 1'b1; base = 2'd2; len = 3'd1;
        tick();
        start = 1'b0;
        expect_beat("sb_b1", 14'h0F0F);
        expect_beat("sb_b2", 14'h3FFF);
        expect_beat("sb_b3", 14'h2AAA);
        check("sb_done", 32'(done), 32'd1);
`ifdef ROM_STREAM_CHECKSUM_EN
        check("sb_csum", 32'(csum), 32'h1A5B);
`endif
        tick();

        // Reset during SEND of beat 2
        start = 1'b1; base = 2'd0; len = 3'd4;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("rm_pre_data", 32'(m_data), 32'h0F0F);
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_valid", 32'(m_valid), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_rom_addr", 32'(rom_addr), 32'd0);
        check("rm_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_valid === 1'b1) seen_valid++;
            if (done === 1'b1) seen_done++;
        end
        check("rm_no_beats", 32'(seen_valid), 32'd0);
        check("rm_no_done", 32'(seen_done), 32'd0);
        check("rm_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
